// File: rtl/branch_pred_pkg.sv
// Helpers for the branch predictor.
// Saturating counter arithmetic and the default counter encodings. The
// counter helpers work on a 4-bit container so every legal counter width
// (1..4) shares one implementation; callers place their counter in the
// low bits and take the low bits of the result.
package branch_pred_pkg;

  localparam int CNT_W_MAX = 4;

  // Largest value representable in a counter of the given width.
  function automatic logic [CNT_W_MAX-1:0] cnt_max(input int unsigned width);
    return CNT_W_MAX'((32'd1 << width) - 32'd1);
  endfunction

  // Weakly taken: the smallest value with the MSB set. Used on allocation.
  function automatic logic [CNT_W_MAX-1:0] cnt_weak_taken(input int unsigned width);
    return CNT_W_MAX'(32'd1 << (width - 1));
  endfunction

  // Weakly not taken: the largest value with the MSB clear. Used on reset.
  function automatic logic [CNT_W_MAX-1:0] cnt_weak_not_taken(input int unsigned width);
    return CNT_W_MAX'((32'd1 << (width - 1)) - 32'd1);
  endfunction

  function automatic logic [CNT_W_MAX-1:0] sat_inc(input logic [CNT_W_MAX-1:0] cnt,
                                                    input int unsigned width);
    logic [CNT_W_MAX-1:0] top;
    top = cnt_max(width);
    return (cnt >= top) ? top : cnt + CNT_W_MAX'(1);
  endfunction

  function automatic logic [CNT_W_MAX-1:0] sat_dec(input logic [CNT_W_MAX-1:0] cnt);
    return (cnt == '0) ? '0 : cnt - CNT_W_MAX'(1);
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the 5-stage MIPS core.
// Provides the machine word type used on every 32-bit datapath port.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, plus resolved-branch and mispredict statistics.
//
// Ports:
//   CLK, nRST            clock (rising edge), async active-low reset
//   lookup_pc            fetch PC, looked up combinationally
//   predict_hit/taken/target  fetch-stage prediction (target 0 on miss)
//   upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken
//                        resolved branch from EX
//   clear                synchronous invalidate of every entry
//   branch_cnt, mispredict_cnt  wrapping statistics counters
module branch_target_buffer
  import cpu_types_pkg::*;
  import branch_pred_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t lookup_pc,
  output logic  predict_hit,
  output logic  predict_taken,
  output word_t predict_target,
  input  logic  upd_en,
  input  word_t upd_pc,
  input  logic  upd_taken,
  input  word_t upd_target,
  input  logic  upd_pred_taken,
  input  logic  clear,
  output word_t branch_cnt,
  output word_t mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(cnt_weak_not_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_weak_taken(CNT_W));

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [29:0]        target_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  word_t            up_pred_target;
  logic             mispredict;

  logic [CNT_W_MAX-1:0] cnt_ext;
  logic [CNT_W_MAX-1:0] cnt_step;
  logic [CNT_W-1:0]     cnt_next;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];

  // Lookup reads only registered state, so a same-cycle update is never
  // bypassed. A miss forces taken and target low even though the stale
  // counter and target of the slot may hold anything.
  assign predict_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign predict_taken  = predict_hit && cnt_q[lk_idx][CNT_W-1];
  assign predict_target = predict_hit ? {target_q[lk_idx], 2'b00} : '0;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // The target fetch would have been redirected to for this branch: the
  // stored target on a hit, zero on a miss (mirrors predict_target).
  assign up_pred_target = up_hit ? {target_q[up_idx], 2'b00} : '0;

  // A correctly predicted direction still costs a flush when a taken
  // branch was steered to a stale target.
  assign mispredict = (upd_pred_taken != upd_taken) ||
                      (upd_taken && upd_pred_taken && (up_pred_target != upd_target));

  // Widen the counter into the shared 4-bit helper container and step it.
  always_comb begin
    cnt_ext                = '0;
    cnt_ext[CNT_W-1:0]     = cnt_q[up_idx];
    cnt_step               = upd_taken ? sat_inc(cnt_ext, CNT_W) : sat_dec(cnt_ext);
  end

  assign cnt_next = cnt_step[CNT_W-1:0];

  // Low PC/target bits are word-aligned and never stored; the upper bits of
  // the widened counter are always zero for narrow counters.
  logic unused_ok;
  assign unused_ok = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0], cnt_step};

  // Table and statistics share one block so that reset discards any update
  // in flight as a whole. Statistics count every resolved branch even when
  // clear suppresses the table write.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      valid_q        <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RESET;
      end
    end else begin
      if (upd_en) begin
        branch_cnt <= branch_cnt + 32'd1;
        if (mispredict) begin
          mispredict_cnt <= mispredict_cnt + 32'd1;
        end
      end

      if (clear) begin
        valid_q <= '0;
      end else if (upd_en) begin
        if (up_hit) begin
          cnt_q[up_idx] <= cnt_next;
          if (upd_taken) begin
            target_q[up_idx] <= upd_target[31:2];
          end
        end else if (upd_taken) begin
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= upd_target[31:2];
          cnt_q[up_idx]    <= CNT_ALLOC;
        end
      end
    end
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised branch predictor for the 5-stage pipelined MIPS core. It replaces the fixed "always taken" fetch-stage decision with a direct-mapped branch target buffer of ENTRIES tagged entries, each holding an N-bit saturating direction counter. Fetch queries it combinationally with the current PC. EX updates it with each resolved branch outcome. It also keeps branch and mispredict statistics.

## Interface
- ENTRIES, 16: table depth; power of two, ≥2; IDX_W = $clog2(ENTRIES).
- CNT_W, 2: saturating counter width, 1..4.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- lookup_pc  in  32  PC of the instruction being fetched.
- predict_hit  out  1  valid entry with matching tag.
- predict_taken  out  1  predict_hit & counter MSB.
- predict_target  out  32  stored target; 0 when predict_hit=0.
- upd_en  in  1  resolved branch in EX this cycle (qualified by pipeline enable).
- upd_pc  in  32  PC of the resolved branch (EX_pc4 − 4).
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual taken target (pc4 + sext(imm)<<2).
- upd_pred_taken  in  1  prediction carried down the pipe with this branch.
- clear  in  1  synchronous invalidate of all entries.
- branch_cnt  out  32  resolved-branch count, wraps.
- mispredict_cnt  out  32  mispredict count, wraps.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2] (30−IDX_W bits). pc[1:0] is ignored.
- Entry contents: valid, tag, target[31:2] (low 2 bits are reconstructed as 00), cnt[CNT_W-1:0].
- Lookup is purely combinational on lookup_pc against the registered table. There is no bypass from a same-cycle update.
- Update when upd_en=1 and clear=0, at upd_pc's index:
  - Hit, taken: cnt saturating +1 (max 2^CNT_W−1); target ← upd_target.
  - Hit, not taken: cnt saturating −1 (min 0); target unchanged.
  - Miss, taken: allocate (overwrites any alias). Set valid=1, new tag, target ← upd_target, cnt=2^(CNT_W−1) (weakly taken).
  - Miss, not taken: no change.
- Statistics, on upd_en=1 (counted regardless of clear):
  - branch_cnt+1.
  - mispredict_cnt+1 if upd_pred_taken≠upd_taken, or if upd_taken and upd_pred_taken and the entry's target≠upd_target before update.
- clear=1: every valid bit ← 0 next edge. Counters and targets are left stale. clear has priority over an update in the same cycle.

## Timing
- Lookup latency 0 cycles. An update is visible to lookup on the cycle after the edge that captures it.
- Same-index lookup and update in one cycle: the lookup returns pre-update contents.
- Reset, effective immediately and asynchronously:
  - All valid bits=0; all cnt=2^(CNT_W−1)−1 (weakly not taken); targets=0.
  - branch_cnt=mispredict_cnt=0.
  - Therefore predict_hit=0, predict_taken=0, predict_target=0.
- Reset asserted mid-update discards that update. No partial entry write is permitted.
- Counters wrap 0xFFFF_FFFF→0 without any flag.
- ENTRIES=2 gives IDX_W=1 and a 29-bit tag. There is no special casing for it.

## Structure
- cpu_types_pkg supplies word_t. Add branch_pred_pkg containing:
  - the sat_inc / sat_dec functions, parametrised by width;
  - the default counter encodings.
- Sub-modules: none required. Store the table as registered arrays (valid vector, tag/target/cnt arrays) with a single write port.
- The datapath instantiates this block. It uses predict_taken/predict_target for pcn and compares them in EX to drive the IF/ID/EX flush.

## Test plan
All scenarios use ENTRIES=16 and CNT_W=2.
- Reset, then lookup_pc=0x0000_0040 → predict_hit=0, predict_taken=0, predict_target=0, both counters 0.
- upd_en, upd_pc=0x40, upd_taken=1, upd_target=0x80, upd_pred_taken=0 → next cycle lookup 0x40: hit=1, taken=1, target=0x80. mispredict_cnt=1, branch_cnt=1.
- Counter saturation at pc 0x40:
  - Three not-taken updates → cnt 2→1→0→0; predict_taken=0 from the first update onward.
  - Then four taken updates → cnt 1,2,3,3; taken=1 once cnt reaches 2.
- Aliasing: 0x40 allocated, then lookup 0x440 (same index 0, tag 0x11 vs 0x1) → hit=0. Then a taken update of 0x440 with target 0x500 → lookup 0x40 now misses and 0x440 hits with target 0x500.
- clear=1 together with a taken upd_en for 0x60 → next cycle all lookups miss, 0x60 is not allocated, branch_cnt still increments.
- Same-cycle lookup and update of 0x40 (taken→not-taken at cnt=2) → that cycle's predict_taken=1. Next cycle cnt=1 and predict_taken=0. Assert nRST during a subsequent update → every output returns to its reset value immediately.
